// File: rtl/neural_pkg.sv
// Shared constants, state encoding and bus helpers for the neuron result collector.
package neural_pkg;

   localparam int NUM_CLASSES = 10;
   localparam int RESULT_W    = 26;
   localparam int IDX_W       = 4;

   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
      COMPARE,
      DONE
   } state_t;

   function automatic logic signed [RESULT_W-1:0] get_slice(
      input logic [NUM_CLASSES*RESULT_W-1:0] bus,
      input int                              k
   );
      return bus[k*RESULT_W +: RESULT_W];
   endfunction

endpackage

// File: rtl/argmax_scan.sv
// Sequential signed max-finder: walks the value array one entry per cycle after start,
// keeping the lowest index on ties.
module argmax_scan
   import neural_pkg::*;
(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic                       abort,
   input  logic signed [RESULT_W-1:0] vals [NUM_CLASSES],
   output logic [IDX_W-1:0]           idx,
   output logic signed [RESULT_W-1:0] best,
   output logic                       busy,
   output logic                       done
);

   logic                       active_q, active_d;
   logic [IDX_W-1:0]           i_q, i_d;
   logic [IDX_W-1:0]           idx_q, idx_d;
   logic signed [RESULT_W-1:0] best_q, best_d;

   always_comb begin
      active_d = active_q;
      i_d      = i_q;
      idx_d    = idx_q;
      best_d   = best_q;
      if (abort) begin
         active_d = 1'b0;
      end else if (active_q) begin
         // strict greater-than keeps the earlier index on equal values
         if (vals[i_q] > best_q) begin
            best_d = vals[i_q];
            idx_d  = i_q;
         end
         i_d = i_q + 1'b1;
         if (i_q == IDX_W'(NUM_CLASSES-1)) active_d = 1'b0;
      end else if (start) begin
         best_d   = vals[0];
         idx_d    = '0;
         i_d      = IDX_W'(1);
         active_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         active_q <= 1'b0;
         i_q      <= '0;
         idx_q    <= '0;
         best_q   <= '0;
      end else begin
         active_q <= active_d;
         i_q      <= i_d;
         idx_q    <= idx_d;
         best_q   <= best_d;
      end
   end

   assign idx  = idx_q;
   assign best = best_q;
   assign busy = active_q;
   assign done = active_q && (i_q == IDX_W'(NUM_CLASSES-1));

endmodule

// File: rtl/neural_argmax_collector.sv
// Collects one signed sum per output neuron in any arrival order, then reports the
// winning class and its score with a one-cycle valid pulse.
module neural_argmax_collector
   import neural_pkg::*;
#(
   parameter int TIMEOUT = 2047
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_CLASSES*RESULT_W-1:0] Result_Bus,
   input  logic [NUM_CLASSES-1:0]          Result_Valid,
   input  logic                            Clear,
   output logic [IDX_W-1:0]                Class_Out,
   output logic [RESULT_W-1:0]             Max_Value,
   output logic                            Output_Valid,
   output logic                            Timeout,
   output logic                            Dup_Err,
   output logic                            Busy
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   state_t                     state_q, state_d;
   logic [NUM_CLASSES-1:0]     flag_q, flag_d, flag_cap;
   logic signed [RESULT_W-1:0] val_q [NUM_CLASSES];
   logic signed [RESULT_W-1:0] val_d [NUM_CLASSES];
   logic [CNT_W-1:0]           cnt_q, cnt_d;
   logic [IDX_W-1:0]           class_q, class_d;
   logic signed [RESULT_W-1:0] max_q, max_d;
   logic                       ovld_q, ovld_d;
   logic                       tout_q, tout_d;
   logic                       dup_q, dup_d;

   logic                       scan_start, scan_busy, scan_done;
   logic [IDX_W-1:0]           scan_idx;
   logic signed [RESULT_W-1:0] scan_best;

   assign scan_start = (state_q == COMPARE) && !scan_busy;

   argmax_scan u_scan (
      .clk   (clk),
      .rst   (rst),
      .start (scan_start),
      .abort (Clear),
      .vals  (val_q),
      .idx   (scan_idx),
      .best  (scan_best),
      .busy  (scan_busy),
      .done  (scan_done)
   );

   always_comb begin
      state_d  = state_q;
      flag_d   = flag_q;
      val_d    = val_q;
      cnt_d    = cnt_q;
      class_d  = class_q;
      max_d    = max_q;
      ovld_d   = 1'b0;
      tout_d   = 1'b0;
      dup_d    = dup_q;
      flag_cap = flag_q | Result_Valid;
      if (Clear) begin
         state_d = IDLE;
         flag_d  = '0;
         dup_d   = 1'b0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE, COLLECT: begin
               for (int k = 0; k < NUM_CLASSES; k++) begin
                  if (Result_Valid[k]) val_d[k] = get_slice(Result_Bus, k);
               end
               flag_d = flag_cap;
               if (state_q == IDLE) begin
                  if (|Result_Valid) begin
                     dup_d   = 1'b0;
                     cnt_d   = '0;
                     state_d = (&flag_cap) ? COMPARE : COLLECT;
                  end
               end else begin
                  if (|(Result_Valid & flag_q)) dup_d = 1'b1;
                  cnt_d = cnt_q + 1'b1;
                  // a completing capture wins over an expiring counter on the same edge
                  if (&flag_cap) begin
                     state_d = COMPARE;
                  end else if (cnt_d == CNT_W'(TIMEOUT)) begin
                     tout_d  = 1'b1;
                     flag_d  = '0;
                     state_d = IDLE;
                  end
               end
            end
            COMPARE: begin
               if (|Result_Valid) dup_d = 1'b1;
               if (scan_done) state_d = DONE;
            end
            DONE: begin
               if (|Result_Valid) dup_d = 1'b1;
               class_d = scan_idx;
               max_d   = scan_best;
               ovld_d  = 1'b1;
               flag_d  = '0;
               state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         flag_q  <= '0;
         for (int k = 0; k < NUM_CLASSES; k++) val_q[k] <= '0;
         cnt_q   <= '0;
         class_q <= '0;
         max_q   <= '0;
         ovld_q  <= 1'b0;
         tout_q  <= 1'b0;
         dup_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         flag_q  <= flag_d;
         val_q   <= val_d;
         cnt_q   <= cnt_d;
         class_q <= class_d;
         max_q   <= max_d;
         ovld_q  <= ovld_d;
         tout_q  <= tout_d;
         dup_q   <= dup_d;
      end
   end

   assign Class_Out    = class_q;
   assign Max_Value    = max_q;
   assign Output_Valid = ovld_q;
   assign Timeout      = tout_q;
   assign Dup_Err      = dup_q;
   assign Busy         = (state_q == COLLECT) || (state_q == COMPARE);

endmodule

// File: tb/tb_neural_argmax_collector.sv
// Randomized and directed bench for the argmax collector against a simple argmax model.
module tb_neural_argmax_collector;

   localparam int N  = 10;
   localparam int W  = 26;
   localparam int TO = 50;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic [N*W-1:0] Result_Bus = '0;
   logic [N-1:0]   Result_Valid = '0;
   logic           Clear = 1'b0;
   logic [3:0]     Class_Out;
   logic [W-1:0]   Max_Value;
   logic           Output_Valid, Timeout, Dup_Err, Busy;

   int checks = 0;
   int errors = 0;

   logic signed [W-1:0] vals [N];
   logic signed [W-1:0] mdl  [N];

   neural_argmax_collector #(.TIMEOUT(TO)) dut (
      .clk          (clk),
      .rst          (rst),
      .Result_Bus   (Result_Bus),
      .Result_Valid (Result_Valid),
      .Clear        (Clear),
      .Class_Out    (Class_Out),
      .Max_Value    (Max_Value),
      .Output_Valid (Output_Valid),
      .Timeout      (Timeout),
      .Dup_Err      (Dup_Err),
      .Busy         (Busy)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // drive one cycle of valids; the model keeps the latest value per class
   task automatic pulse(input logic [N-1:0] mask, input logic clr);
      for (int k = 0; k < N; k++) begin
         if (mask[k]) begin
            Result_Bus[k*W +: W] = vals[k];
            if (!clr) mdl[k] = vals[k];
         end
      end
      Result_Valid = mask;
      Clear        = clr;
      step();
      Result_Valid = '0;
      Clear        = 1'b0;
   endtask

   task automatic wait_output(output int n);
      n = -1;
      for (int i = 1; i <= 40; i++) begin
         step();
         if (Output_Valid === 1'b1) begin
            n = i;
            break;
         end
      end
   endtask

   function automatic void ref_argmax(output int ci, output logic signed [W-1:0] mv);
      ci = 0;
      mv = mdl[0];
      for (int i = 1; i < N; i++) begin
         if (mdl[i] > mv) begin
            ci = i;
            mv = mdl[i];
         end
      end
   endfunction

   function automatic logic signed [W-1:0] rand_val(input int mode);
      int t;
      case (mode)
         0: rand_val = W'($urandom);
         1: begin t = int'($urandom_range(0, 4)) - 2; rand_val = W'(t); end
         default: rand_val = ($urandom_range(0, 1) == 0) ? 26'h2000000 : 26'h1FFFFFF;
      endcase
   endfunction

   task automatic test_reset();
      rst = 1'b0;
      repeat (2) step();
      checks++;
      if ({Class_Out, Max_Value, Output_Valid, Timeout, Dup_Err, Busy} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got cls=%0d max=%h ov=%b to=%b dup=%b busy=%b, want all 0",
                  Class_Out, Max_Value, Output_Valid, Timeout, Dup_Err, Busy);
      end
      rst = 1'b1;
      step();
   endtask

   task automatic test_staggered();
      int n;
      int exp_v [N] = '{5, -3, 100, 7, 0, 99, -200, 1, 2, 3};
      for (int k = 0; k < N; k++) vals[k] = W'(exp_v[k]);
      for (int k = 0; k < N; k++) begin
         pulse(N'(1) << k, 1'b0);
         if (k == 4) begin
            checks++;
            if (Busy !== 1'b1) begin errors++; $display("FAIL stag_busy: got %b want 1", Busy); end
         end
      end
      wait_output(n);
      checks++;
      if (n != 11) begin errors++; $display("FAIL stag_latency: got %0d want 11", n); end
      checks++;
      if (Class_Out !== 4'd2 || Max_Value !== 26'd100) begin
         errors++;
         $display("FAIL stag_result: got cls=%0d max=%h want cls=2 max=%h", Class_Out, Max_Value, 26'd100);
      end
      step();
      checks++;
      if (Output_Valid !== 1'b0 || Class_Out !== 4'd2 || Dup_Err !== 1'b0) begin
         errors++;
         $display("FAIL stag_pulse_hold: got ov=%b cls=%0d dup=%b want ov=0 cls=2 dup=0", Output_Valid, Class_Out, Dup_Err);
      end
   endtask

   task automatic test_simultaneous();
      int n;
      for (int k = 0; k < N; k++) vals[k] = 26'h3FFFFFF;
      pulse('1, 1'b0);
      step();
      // a late valid during COMPARE must be dropped and flagged
      vals[3] = 26'h1FFFFFF;
      pulse(N'(1) << 3, 1'b0);
      wait_output(n);
      checks++;
      if (n + 2 != 11) begin errors++; $display("FAIL simul_latency: got %0d want 11", n + 2); end
      checks++;
      if (Class_Out !== 4'd0 || Max_Value !== 26'h3FFFFFF) begin
         errors++;
         $display("FAIL simul_result: got cls=%0d max=%h want cls=0 max=3ffffff", Class_Out, Max_Value);
      end
      checks++;
      if (Dup_Err !== 1'b1) begin errors++; $display("FAIL simul_late_dup: got %b want 1", Dup_Err); end
   endtask

   task automatic test_duplicate();
      int n;
      for (int k = 0; k < N; k++) vals[k] = 26'd20;
      vals[4] = 26'd500;
      pulse(N'(1) << 4, 1'b0);
      checks++;
      if (Dup_Err !== 1'b0) begin errors++; $display("FAIL dup_cleared_on_start: got %b want 0", Dup_Err); end
      for (int k = 0; k < 9; k++) if (k != 4) pulse(N'(1) << k, 1'b0);
      vals[4] = 26'd10;
      pulse(N'(1) << 4, 1'b0);
      checks++;
      if (Dup_Err !== 1'b1) begin errors++; $display("FAIL dup_flag: got %b want 1", Dup_Err); end
      pulse(N'(1) << 9, 1'b0);
      wait_output(n);
      checks++;
      if (n != 11 || Class_Out !== 4'd0 || Max_Value !== 26'd20 || Dup_Err !== 1'b1) begin
         errors++;
         $display("FAIL dup_result: got lat=%0d cls=%0d max=%h dup=%b want lat=11 cls=0 max=%h dup=1",
                  n, Class_Out, Max_Value, Dup_Err, 26'd20);
      end
   endtask

   task automatic test_timeout();
      int tcnt = -1;
      int tpulses = 0;
      int ovs = 0;
      int ci, n;
      logic signed [W-1:0] mv;
      for (int k = 0; k < N; k++) vals[k] = rand_val(0);
      pulse(N'(1), 1'b0);
      for (int k = 1; k < 9; k++) pulse(N'(1) << k, 1'b0);
      for (int i = 9; i <= 80; i++) begin
         step();
         if (Timeout === 1'b1) begin
            tpulses++;
            if (tcnt < 0) tcnt = i;
         end
         if (Output_Valid === 1'b1) ovs++;
      end
      checks++;
      if (tcnt != TO || tpulses != 1) begin
         errors++;
         $display("FAIL timeout_pulse: got at=%0d count=%0d want at=%0d count=1", tcnt, tpulses, TO);
      end
      checks++;
      if (ovs != 0 || Busy !== 1'b0) begin
         errors++;
         $display("FAIL timeout_idle: got ov_pulses=%0d busy=%b want 0 0", ovs, Busy);
      end
      for (int k = 0; k < N; k++) vals[k] = rand_val(0);
      for (int k = N - 1; k >= 0; k--) pulse(N'(1) << k, 1'b0);
      wait_output(n);
      ref_argmax(ci, mv);
      checks++;
      if (n != 11 || Class_Out !== 4'(ci) || Max_Value !== mv) begin
         errors++;
         $display("FAIL timeout_next_frame: got lat=%0d cls=%0d max=%h want lat=11 cls=%0d max=%h",
                  n, Class_Out, Max_Value, ci, mv);
      end
   endtask

   task automatic test_clear_final();
      logic [3:0]   prev_c;
      logic [W-1:0] prev_m;
      int           ovs = 0;
      int           ci, n;
      logic signed [W-1:0] mv;
      prev_c = Class_Out;
      prev_m = Max_Value;
      for (int k = 0; k < N; k++) vals[k] = rand_val(0);
      for (int k = 0; k < 9; k++) pulse(N'(1) << k, 1'b0);
      pulse(N'(1) << 9, 1'b1);
      for (int i = 0; i < 15; i++) begin
         if (Output_Valid === 1'b1 || Timeout === 1'b1) ovs++;
         step();
      end
      checks++;
      if (ovs != 0 || Busy !== 1'b0 || Dup_Err !== 1'b0) begin
         errors++;
         $display("FAIL clear_abort: got pulses=%0d busy=%b dup=%b want 0 0 0", ovs, Busy, Dup_Err);
      end
      checks++;
      if (Class_Out !== prev_c || Max_Value !== prev_m) begin
         errors++;
         $display("FAIL clear_hold: got cls=%0d max=%h want cls=%0d max=%h", Class_Out, Max_Value, prev_c, prev_m);
      end
      for (int k = 0; k < N; k++) vals[k] = rand_val(1);
      for (int k = 0; k < N; k++) pulse(N'(1) << k, 1'b0);
      wait_output(n);
      ref_argmax(ci, mv);
      checks++;
      if (n != 11 || Class_Out !== 4'(ci) || Max_Value !== mv) begin
         errors++;
         $display("FAIL clear_next_frame: got lat=%0d cls=%0d max=%h want lat=11 cls=%0d max=%h",
                  n, Class_Out, Max_Value, ci, mv);
      end
   endtask

   task automatic test_async_reset();
      int ovs = 0;
      int ci, n;
      logic signed [W-1:0] mv;
      for (int k = 0; k < N; k++) vals[k] = rand_val(0);
      vals[0] = 26'h0ABCDEF;
      pulse('1, 1'b0);
      step();
      pulse('1, 1'b0);
      repeat (3) step();
      #3;
      rst = 1'b0;
      #1;
      checks++;
      if ({Class_Out, Max_Value, Output_Valid, Timeout, Dup_Err, Busy} !== '0) begin
         errors++;
         $display("FAIL async_reset: got cls=%0d max=%h ov=%b to=%b dup=%b busy=%b want all 0",
                  Class_Out, Max_Value, Output_Valid, Timeout, Dup_Err, Busy);
      end
      #2;
      rst = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         if (Output_Valid === 1'b1 || Busy === 1'b1) ovs++;
      end
      checks++;
      if (ovs != 0) begin errors++; $display("FAIL async_reset_quiet: got %0d active cycles want 0", ovs); end
      for (int k = 0; k < N; k++) vals[k] = rand_val(0);
      pulse(10'h155, 1'b0);
      pulse(10'h2AA, 1'b0);
      wait_output(n);
      ref_argmax(ci, mv);
      checks++;
      if (n != 11 || Class_Out !== 4'(ci) || Max_Value !== mv) begin
         errors++;
         $display("FAIL async_next_frame: got lat=%0d cls=%0d max=%h want lat=11 cls=%0d max=%h",
                  n, Class_Out, Max_Value, ci, mv);
      end
   endtask

   task automatic test_random_frames();
      int arr [N];
      int last, ci, n, mode;
      logic [N-1:0] mask;
      logic signed [W-1:0] mv;
      for (int f = 0; f < 25; f++) begin
         mode = (f == 0) ? 3 : int'($urandom_range(0, 2));
         for (int k = 0; k < N; k++) begin
            vals[k] = (mode == 3) ? 26'h2000000 : rand_val(mode);
            arr[k]  = (k == 0) ? 0 : int'($urandom_range(0, 12));
         end
         last = 0;
         for (int k = 0; k < N; k++) if (arr[k] > last) last = arr[k];
         for (int c = 0; c <= last; c++) begin
            mask = '0;
            for (int k = 0; k < N; k++) if (arr[k] == c) mask[k] = 1'b1;
            pulse(mask, 1'b0);
         end
         wait_output(n);
         ref_argmax(ci, mv);
         checks++;
         if (n != 11 || Class_Out !== 4'(ci) || Max_Value !== mv || Dup_Err !== 1'b0) begin
            errors++;
            $display("FAIL random_frame_%0d: got lat=%0d cls=%0d max=%h dup=%b want lat=11 cls=%0d max=%h dup=0",
                     f, n, Class_Out, Max_Value, Dup_Err, ci, mv);
         end
         repeat (int'($urandom_range(0, 3))) step();
      end
   endtask

   initial begin
      for (int k = 0; k < N; k++) begin
         vals[k] = '0;
         mdl[k]  = '0;
      end
      test_reset();
      test_staggered();
      test_simultaneous();
      test_duplicate();
      test_timeout();
      test_clear_final();
      test_async_reset();
      test_random_frames();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
